spi_target_bridge: RTL

- SPI target (responder) for the bit-banged SPI master on the MC14500 core: CPU drives SCLK/SDO by software, samples SDI.
- Oversamples the slow software-generated SPI with clk_i.
- Converts framed transactions into single-cycle register write strobes and register read fetches on a local parallel bus.
- Sits between the core's SCLK/SDO/SDI pins and a small peripheral register file.

---
 rtl/spi_target_bridge_if.sv | 17 +
 rtl/spi_target_bridge.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spi_target_bridge_if.sv
// Local register bus between the SPI target bridge and a small peripheral
// register file.
//   master : the bridge; drives write strobe/address/data and read address,
//            and takes read data back.
//   slave  : the register file; returns rd_data combinationally from rd_addr.
interface spi_target_bridge_if #(
  parameter int ADDR_W = 4
);
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  modport master (output wr_strobe, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_strobe, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/spi_target_bridge.sv
// SPI target (mode 0, MSB first) for a slow, software-driven SPI controller.
// The SPI pins are oversampled with clk_i. Framed transactions are turned
// into single-cycle register write strobes and register read fetches.
//
// Frame layout: command byte {rw, ignored, addr[ADDR_W-1:0]}, then data
// bytes. The address auto-increments per byte and wraps mod 2^ADDR_W.
//
// Ports:
//   clk_i, rst_n      system clock, synchronous active-low reset
//   spi_cs_n          chip select (async to clk_i)
//   spi_sclk          SPI clock, mode 0, at most clk_i/8
//   spi_mosi          controller-to-target data
//   spi_miso          target-to-controller data (registered)
//   spi_miso_oe       high while the synchronized CS is asserted
//   frame_active      high while a frame is being decoded
//   bus               register bus (write strobe/addr/data, read addr/data)
module spi_target_bridge #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_n,
  input  logic                        spi_cs_n,
  input  logic                        spi_sclk,
  input  logic                        spi_mosi,
  output logic                        spi_miso,
  output logic                        spi_miso_oe,
  output logic                        frame_active,
  spi_target_bridge_if.master         bus
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_rise, cs_fall, sclk_rise, sclk_fall;

  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_q, rx_d;      // only 7 bits need holding; the 8th arrives live
  logic [7:0]        rx_next;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              load_q, load_d;  // reload tx_q from rd_data this cycle
  logic              skip_q, skip_d;  // swallow the falling edge that closes a byte
  logic              byte_done;

  // Synchronizers plus one extra sample for edge detection. CS idles high.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q[0]   <= spi_cs_n;
      sclk_sync_q[0] <= spi_sclk;
      mosi_sync_q[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync_q[i]   <= cs_sync_q[i-1];
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_rise   =  cs_s   & ~cs_prev_q;
  assign cs_fall   = ~cs_s   &  cs_prev_q;
  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;

  assign rx_next   = {rx_q, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      load_q      <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      load_q      <= load_d;
      skip_q      <= skip_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    load_d      = 1'b0;
    skip_d      = skip_q;

    // rd_data settles one cycle after rd_addr moved.
    if (load_q) tx_d = bus.rd_data;

    // CS release wins over any simultaneous sclk edge; partial bytes are dropped.
    if (cs_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      tx_d      = '0;
      load_d    = 1'b0;
      skip_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d   = CMD;
            bit_cnt_d = '0;
            rx_d      = '0;
            tx_d      = '0;
            skip_d    = 1'b0;
          end
        end
        default: begin
          if (sclk_rise) begin
            rx_d      = rx_next[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (sclk_fall) begin
            if (skip_q) skip_d = 1'b0;
            else        tx_d   = {tx_q[6:0], 1'b0};
          end
          if (byte_done) begin
            case (state_q)
              CMD: begin
                addr_d = rx_next[ADDR_W-1:0];
                if (rx_next[7]) begin
                  state_d   = RDATA;
                  rd_addr_d = rx_next[ADDR_W-1:0];
                  load_d    = 1'b1;
                  skip_d    = 1'b1;
                end else begin
                  state_d   = WDATA;
                end
              end
              WDATA: begin
                wr_addr_d   = addr_q;
                wr_data_d   = rx_next;
                wr_strobe_d = 1'b1;
                addr_d      = addr_q + 1'b1;
              end
              RDATA: begin
                addr_d    = addr_q + 1'b1;
                rd_addr_d = addr_q + 1'b1;
                load_d    = 1'b1;
                skip_d    = 1'b1;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign spi_miso      = tx_q[7];
  assign spi_miso_oe   = ~cs_s;
  assign frame_active  = (state_q != IDLE);
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_addr   = rd_addr_q;

endmodule
